// File: rtl/adas_pkg.sv
// adas_pkg
// Shared definitions for the ADAS brake controller slice.
//   state_t : controller FSM state encoding
//   max()   : integer maximum, used to size the shared confirm/hold counter
package adas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM,
        BRAKE,
        HOLD,
        FAULT
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adas_brake_ctrl_if.sv
// adas_brake_ctrl_if
// Signal bundle between the sensor front-end / pedal and the brake controller.
//   driver_break  : brake pedal
//   camera, radar : per-channel object flags
//   adas_error    : ADAS error indication
//   error_clear   : request to leave the fault state
//   vehicle_break : brake request to the engine actuator
//   adas_break    : registered ADAS brake contribution
//   adas_fault    : high while the controller is in FAULT
//   channel_hits  : registered per-channel camera & radar coincidence
// master = side driving the sensor/pedal inputs, slave = controller.
interface adas_brake_ctrl_if #(
    parameter int NUM_CHANNELS = 2
);
    logic                    driver_break;
    logic [NUM_CHANNELS-1:0] camera;
    logic [NUM_CHANNELS-1:0] radar;
    logic                    adas_error;
    logic                    error_clear;
    logic                    vehicle_break;
    logic                    adas_break;
    logic                    adas_fault;
    logic [NUM_CHANNELS-1:0] channel_hits;

    modport master (
        output driver_break, camera, radar, adas_error, error_clear,
        input  vehicle_break, adas_break, adas_fault, channel_hits
    );

    modport slave (
        input  driver_break, camera, radar, adas_error, error_clear,
        output vehicle_break, adas_break, adas_fault, channel_hits
    );
endinterface

// File: rtl/adas_channel_fuse.sv
// adas_channel_fuse
// Combinational sensor fusion: a channel hits when camera and radar agree,
// and an object is detected when any channel hits.
//   camera, radar : per-channel object flags
//   hits          : per-channel coincidence
//   detect        : OR of all hits
module adas_channel_fuse #(
    parameter int NUM_CHANNELS = 2
) (
    input  logic [NUM_CHANNELS-1:0] camera,
    input  logic [NUM_CHANNELS-1:0] radar,
    output logic [NUM_CHANNELS-1:0] hits,
    output logic                    detect
);

    assign hits   = camera & radar;
    assign detect = |hits;

endmodule

// File: rtl/adas_brake_ctrl.sv
// adas_brake_ctrl
// ADAS brake controller: confirms a fused detection for CONFIRM_CYCLES before
// braking, holds the brake HOLD_CYCLES after the object clears, and latches
// ADAS errors into a sticky fault. The driver pedal path is combinational and
// bypasses all ADAS logic.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : adas_brake_ctrl_if.slave (pedal, sensors, error, brake outputs)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no object, counter cleared
// CONFIRM | object seen, counting consecutive detect cycles
// BRAKE   | ADAS braking, object still present
// HOLD    | ADAS braking, object gone, counting hold cycles
// FAULT   | ADAS error latched, ADAS brake off until cleared
module adas_brake_ctrl
    import adas_pkg::*;
#(
    parameter int NUM_CHANNELS   = 2,
    parameter int CONFIRM_CYCLES = 3,
    parameter int HOLD_CYCLES    = 4
) (
    input logic             clock,
    input logic             reset_n,
    adas_brake_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(max(CONFIRM_CYCLES, HOLD_CYCLES) + 1);

    // Terminal counts expressed as "cnt + 1 == N" folded into cnt == N - 1.
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    logic [NUM_CHANNELS-1:0] hits;
    logic                    detect;
    logic                    adas_break_q;
    logic                    adas_fault_q;
    logic [NUM_CHANNELS-1:0] hits_q;

    adas_channel_fuse #(
        .NUM_CHANNELS(NUM_CHANNELS)
    ) u_fuse (
        .camera (bus.camera),
        .radar  (bus.radar),
        .hits   (hits),
        .detect (detect)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            adas_break_q <= 1'b0;
            adas_fault_q <= 1'b0;
            hits_q       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            adas_break_q <= (state_nxt == BRAKE) || (state_nxt == HOLD);
            adas_fault_q <= (state_nxt == FAULT);
            hits_q       <= hits;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (bus.adas_error) begin
            state_nxt = FAULT;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (detect) begin
                        if (CONFIRM_CYCLES == 1) begin
                            state_nxt = BRAKE;
                        end else begin
                            state_nxt = CONFIRM;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (!detect) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CONFIRM_LAST) begin
                        state_nxt = BRAKE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                BRAKE: begin
                    if (!detect) begin
                        state_nxt = HOLD;
                        cnt_nxt   = '0;
                    end
                end
                HOLD: begin
                    if (detect) begin
                        state_nxt = BRAKE;
                        cnt_nxt   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                FAULT: begin
                    // adas_error is already known low on this branch.
                    if (bus.error_clear) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Error masks the ADAS contribution in the same cycle; pedal always passes.
    assign bus.vehicle_break = bus.driver_break | (adas_break_q & ~bus.adas_error);
    assign bus.adas_break    = adas_break_q;
    assign bus.adas_fault    = adas_fault_q;
    assign bus.channel_hits  = hits_q;

endmodule
